// File: rtl/qedmma_pkg.sv
// Shared fixed-point types, widths and the round/saturate helper used by the
// matrix blocks of the filter update chain.
package qedmma_pkg;

    localparam int unsigned STATE_DIM  = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FRAC_BITS  = 16;
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 2;
    localparam int unsigned IDX_W      = $clog2(STATE_DIM);

    typedef logic signed [DATA_WIDTH-1:0] fp_t;

    localparam fp_t FP_ONE = fp_t'(32'sh0001_0000);

    typedef struct packed {
        fp_t  val;
        logic ovf;
    } fp_rs_t;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_MAC,
        MM_WRITE,
        MM_DONE
    } mm_state_t;

    localparam logic [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(1) << (FRAC_BITS - 1);

    // Rescale a wide accumulator to fp_t; in range when all bits above bit 31 match the sign.
    function automatic fp_rs_t fp_round_sat(input logic signed [ACC_WIDTH-1:0] acc,
                                            input logic round_en,
                                            input logic sat_en);
        logic signed [ACC_WIDTH-1:0] biased;
        logic signed [ACC_WIDTH-1:0] shifted;
        logic                        in_range;
        fp_rs_t                      res;
        biased   = acc + $signed(round_en ? HALF_LSB : '0);
        shifted  = biased >>> FRAC_BITS;
        in_range = (&shifted[ACC_WIDTH-1:DATA_WIDTH-1]) | ~(|shifted[ACC_WIDTH-1:DATA_WIDTH-1]);
        res.ovf  = sat_en & ~in_range;
        if (res.ovf) begin
            res.val = shifted[ACC_WIDTH-1] ? fp_t'(32'sh8000_0000) : fp_t'(32'sh7FFF_FFFF);
        end else begin
            res.val = shifted[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/matrix_multiply_4x4_mac.sv
// Registered signed multiply-accumulate, kept separate so it maps onto a DSP slice.
module fp_mac
    import qedmma_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        acc_clr,
    input  logic                        en,
    input  fp_t                         a,
    input  fp_t                         b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    always_comb begin
        prod  = PROD_WIDTH'(a) * PROD_WIDTH'(b);
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_multiply_4x4.sv
// Sequential 4x4 fixed-point matrix multiply C = A x B, one MAC per cycle,
// row-major element order, start/done handshake shared with the inverter.
module matrix_multiply_4x4
    import qedmma_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  fp_t  A [STATE_DIM][STATE_DIM],
    input  fp_t  B [STATE_DIM][STATE_DIM],
    output fp_t  C [STATE_DIM][STATE_DIM],
    output logic done,
    output logic busy,
    output logic overflow
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STATE_DIM - 1);

    mm_state_t        state_d, state_q;
    fp_t              a_d [STATE_DIM][STATE_DIM];
    fp_t              a_q [STATE_DIM][STATE_DIM];
    fp_t              b_d [STATE_DIM][STATE_DIM];
    fp_t              b_q [STATE_DIM][STATE_DIM];
    fp_t              c_d [STATE_DIM][STATE_DIM];
    fp_t              c_q [STATE_DIM][STATE_DIM];
    logic [IDX_W-1:0] i_d, i_q, j_d, j_q, k_d, k_q;
    logic             done_d, done_q;
    logic             busy_d, busy_q;
    logic             ovf_d, ovf_q;

    logic                        acc_clr_c;
    logic                        mac_en_c;
    logic signed [ACC_WIDTH-1:0] acc;
    fp_rs_t                      rs_c;

    fp_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (acc_clr_c),
        .en      (mac_en_c),
        .a       (a_q[i_q][k_q]),
        .b       (b_q[k_q][j_q]),
        .acc     (acc)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        acc_clr_c = 1'b0;
        mac_en_c  = 1'b0;
        rs_c      = fp_round_sat(acc, ROUND_EN, SAT_EN);

        unique case (state_q)
            MM_IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    ovf_d     = 1'b0;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    acc_clr_c = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = MM_MAC;
                end
            end
            MM_MAC: begin
                mac_en_c = 1'b1;
                k_d      = k_q + IDX_W'(1);
                if (k_q == IDX_LAST) begin
                    state_d = MM_WRITE;
                end
            end
            MM_WRITE: begin
                c_d[i_q][j_q] = rs_c.val;
                ovf_d         = ovf_q | rs_c.ovf;
                acc_clr_c     = 1'b1;
                k_d           = '0;
                j_d           = j_q + IDX_W'(1);
                if (j_q == IDX_LAST) begin
                    i_d = i_q + IDX_W'(1);
                end
                state_d = ((i_q == IDX_LAST) && (j_q == IDX_LAST)) ? MM_DONE : MM_MAC;
            end
            MM_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = MM_IDLE;
            end
            default: state_d = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MM_IDLE;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '{default: '0};
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign C        = c_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_matrix_multiply_4x4.sv
// Directed bench for matrix_multiply_4x4: a rounding and a truncating instance share stimulus.
module tb_matrix_multiply_4x4;
    import qedmma_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    fp_t  a_in [STATE_DIM][STATE_DIM];
    fp_t  b_in [STATE_DIM][STATE_DIM];
    fp_t  c_r  [STATE_DIM][STATE_DIM];
    fp_t  c_t  [STATE_DIM][STATE_DIM];
    logic done_r, busy_r, ovf_r;
    logic done_t, busy_t, ovf_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_multiply_4x4 #(.ROUND_EN(1'b1), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .C(c_r), .done(done_r), .busy(busy_r), .overflow(ovf_r)
    );

    matrix_multiply_4x4 #(.ROUND_EN(1'b0), .SAT_EN(1'b1)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .C(c_t), .done(done_t), .busy(busy_t), .overflow(ovf_t)
    );

    // Start one operation and observe 100 cycles after the accepting edge.
    task automatic run_op(input int pulse_a, input int pulse_b, input int rst_at,
                          output int lat, output int busy_cnt, output int done_cnt);
        lat = 0; busy_cnt = 0; done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (busy_r) busy_cnt++;
            if (done_r) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
            if ((pulse_a != 0 && c == pulse_a) || (pulse_b != 0 && c == pulse_b)) begin
                start = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int k = 0; k < 4; k++) a_in[r][k] = a_in[r][k] + FP_ONE;
            end
            if ((pulse_a != 0 && c == pulse_a + 1) || (pulse_b != 0 && c == pulse_b + 1))
                start = 1'b0;
            if (rst_at != 0 && c == rst_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (busy_r !== 1'b0 || done_r !== 1'b0 || c_r[1][1] !== 32'sh0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs busy=%b done=%b c11=%h required 0 0 0",
                             busy_r, done_r, c_r[1][1]);
                end
            end
            if (rst_at != 0 && c == rst_at + 1) rst_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh0) begin
                    errors++;
                    $display("FAIL reset_c[%0d][%0d] got %h required 0", r, c, c_r[r][c]);
                end
            end
        checks++;
        if ({done_r, busy_r, ovf_r} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b required 000", {done_r, busy_r, ovf_r});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int lat, bc, dc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_in[r][c] = (r == c) ? FP_ONE : 32'sh0;
                b_in[r][c] = 32'sh0001_0000 * (4 * r + c + 1);
            end
        run_op(0, 0, 0, lat, bc, dc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh0001_0000 * (4 * r + c + 1)) begin
                    errors++;
                    $display("FAIL identity_c[%0d][%0d] got %h required %h", r, c, c_r[r][c],
                             32'sh0001_0000 * (4 * r + c + 1));
                end
            end
        checks++;
        if (lat != 81) begin errors++; $display("FAIL identity_latency got %0d required 81", lat); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL identity_done_count got %0d required 1", dc); end
        checks++;
        if (ovf_r !== 1'b0) begin errors++; $display("FAIL identity_overflow got %b required 0", ovf_r); end
    endtask

    task automatic test_scale();
        int lat, bc, dc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_in[r][c] = (r == c) ? 32'sh0002_0000 : 32'sh0;
                b_in[r][c] = 32'sh0000_8000;
            end
        run_op(0, 0, 0, lat, bc, dc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh0001_0000) begin
                    errors++;
                    $display("FAIL scale_c[%0d][%0d] got %h required 00010000", r, c, c_r[r][c]);
                end
            end
        checks++;
        if (bc != 81) begin errors++; $display("FAIL scale_busy_cycles got %0d required 81", bc); end
    endtask

    task automatic test_saturate();
        int lat, bc, dc;
        a_in = '{default: 32'sh7FFF_FFFF};
        b_in = '{default: 32'sh7FFF_FFFF};
        run_op(0, 0, 0, lat, bc, dc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh7FFF_FFFF) begin
                    errors++;
                    $display("FAIL sat_pos_c[%0d][%0d] got %h required 7fffffff", r, c, c_r[r][c]);
                end
            end
        checks++;
        if (ovf_r !== 1'b1) begin errors++; $display("FAIL sat_pos_overflow got %b required 1", ovf_r); end
        b_in = '{default: 32'sh8000_0000};
        run_op(0, 0, 0, lat, bc, dc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh8000_0000) begin
                    errors++;
                    $display("FAIL sat_neg_c[%0d][%0d] got %h required 80000000", r, c, c_r[r][c]);
                end
            end
        checks++;
        if (ovf_r !== 1'b1) begin errors++; $display("FAIL sat_neg_overflow got %b required 1", ovf_r); end
    endtask

    task automatic test_zero();
        int lat, bc, dc;
        a_in = '{default: 32'sh0};
        b_in = '{default: 32'sh0};
        run_op(0, 0, 0, lat, bc, dc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh0) begin
                    errors++;
                    $display("FAIL zero_c[%0d][%0d] got %h required 0", r, c, c_r[r][c]);
                end
            end
        checks++;
        if (ovf_r !== 1'b0) begin errors++; $display("FAIL zero_overflow got %b required 0", ovf_r); end
    endtask

    task automatic test_rounding();
        int lat, bc, dc;
        a_in = '{default: 32'sh0};
        b_in = '{default: 32'sh0};
        a_in[0][0] = 32'sh0000_0001;
        b_in[0][0] = 32'sh0000_8000;
        run_op(0, 0, 0, lat, bc, dc);
        checks++;
        if (c_r[0][0] !== 32'sh0000_0001) begin
            errors++; $display("FAIL round_pos got %h required 00000001", c_r[0][0]);
        end
        checks++;
        if (c_t[0][0] !== 32'sh0000_0000) begin
            errors++; $display("FAIL trunc_pos got %h required 00000000", c_t[0][0]);
        end
        a_in[0][0] = 32'shFFFF_FFFF;
        run_op(0, 0, 0, lat, bc, dc);
        checks++;
        if (c_r[0][0] !== 32'sh0000_0000) begin
            errors++; $display("FAIL round_neg got %h required 00000000", c_r[0][0]);
        end
        checks++;
        if (c_t[0][0] !== 32'shFFFF_FFFF) begin
            errors++; $display("FAIL trunc_neg got %h required ffffffff", c_t[0][0]);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc, dc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_in[r][c] = (r == c) ? FP_ONE : 32'sh0;
                b_in[r][c] = 32'sh0000_4000 * (r + 2 * c + 1);
            end
        run_op(10, 40, 0, lat, bc, dc);
        checks++;
        if (dc != 1) begin errors++; $display("FAIL busy_start_done_count got %0d required 1", dc); end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (c_r[r][c] !== 32'sh0000_4000 * (r + 2 * c + 1)) begin
                    errors++;
                    $display("FAIL busy_start_c[%0d][%0d] got %h required %h", r, c, c_r[r][c],
                             32'sh0000_4000 * (r + 2 * c + 1));
                end
            end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dc;
        int diff;
        fp_t want;
        a_in = '{default: 32'sh0001_0000};
        b_in = '{default: 32'sh0001_0000};
        run_op(0, 0, 30, lat, bc, dc);
        checks++;
        if (dc != 0) begin errors++; $display("FAIL mid_reset_done_count got %0d required 0", dc); end
        checks++;
        if (c_r[3][3] !== 32'sh0) begin errors++; $display("FAIL mid_reset_c33 got %h required 0", c_r[3][3]); end
        a_in = '{default: 32'sh0};
        b_in = '{default: 32'sh0};
        a_in[0][0] = 32'sh0002_0000; b_in[0][0] = 32'sh0000_8000;
        a_in[1][1] = 32'sh0004_0000; b_in[1][1] = 32'sh0000_4000;
        a_in[2][2] = 32'sh0008_0000; b_in[2][2] = 32'sh0000_2000;
        a_in[3][3] = 32'sh0010_0000; b_in[3][3] = 32'sh0000_1000;
        run_op(0, 0, 0, lat, bc, dc);
        checks++;
        if (dc != 1) begin errors++; $display("FAIL inv_chain_done_count got %0d required 1", dc); end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                want = (r == c) ? FP_ONE : 32'sh0;
                diff = int'(c_r[r][c]) - int'(want);
                checks++;
                if (diff > 4 || diff < -4) begin
                    errors++;
                    $display("FAIL inv_chain_c[%0d][%0d] got %h required %h +-4", r, c, c_r[r][c], want);
                end
            end
    endtask

    initial begin
        a_in = '{default: 32'sh0};
        b_in = '{default: 32'sh0};
        test_reset();
        test_identity();
        test_scale();
        test_saturate();
        test_zero();
        test_rounding();
        test_start_while_busy();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
